// File: rtl/sensor_pkg.sv
// Shared types and helpers for the sensor readout path: default geometry,
// buffered row entry, serialiser states and one-hot row-select helpers.
package sensor_pkg;

  localparam int DEF_ARRAY_WIDTH  = 4;
  localparam int DEF_ARRAY_HEIGHT = 4;
  localparam int DEF_PIXEL_BITS   = 8;

  // Widest row-select vector the one-hot helpers accept.
  localparam int SEL_MAX = 32;

  // Index width: clog2 of the count, never narrower than one bit.
  function automatic int idx_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  // Row entry at the default geometry; the top re-declares it for its own sizes.
  typedef struct packed {
    logic [idx_w(DEF_ARRAY_HEIGHT)-1:0]          row;
    logic [DEF_ARRAY_WIDTH*DEF_PIXEL_BITS-1:0]   data;
  } row_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // True when exactly one bit of v is set.
  function automatic logic onehot_valid(input logic [SEL_MAX-1:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < SEL_MAX; i++) begin
      if (v[i]) begin
        n = n + 6'd1;
      end else begin
        n = n;
      end
    end
    return (n == 6'd1);
  endfunction

  // Index of the set bit of a one-hot vector.
  function automatic logic [4:0] onehot_encode(input logic [SEL_MAX-1:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < SEL_MAX; i++) begin
      if (v[i]) begin
        idx = 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/row_fifo.sv
// Two-entry row buffer. A push while full is accepted only if a pop frees a
// slot in the same cycle; otherwise it is ignored and the contents stay put.
module row_fifo
  import sensor_pkg::*;
#(
  parameter type entry_t = row_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output entry_t head,
  output entry_t next,
  output logic   empty,
  output logic   full
);

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push_s;
  logic       do_pop_s;

  // Next-state pointers, storage and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop && (count_q != 2'd0);
    do_push_s = push && ((count_q != 2'd2) || do_pop_s);
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign next  = mem_q[~rd_ptr_q];
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);

endmodule

// File: rtl/pixel_readout.sv
// Captures each released pixel-array row, buffers up to two rows and streams
// them out one pixel per handshake with frame markers and sticky error flags.
module pixel_readout
  import sensor_pkg::*;
#(
  parameter  int PIXEL_ARRAY_WIDTH  = DEF_ARRAY_WIDTH,
  parameter  int PIXEL_ARRAY_HEIGHT = DEF_ARRAY_HEIGHT,
  parameter  int PIXEL_BITS         = DEF_PIXEL_BITS,
  localparam int ROW_W              = idx_w(PIXEL_ARRAY_HEIGHT),
  localparam int COL_W              = idx_w(PIXEL_ARRAY_WIDTH)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    p_erase,
  input  logic [PIXEL_ARRAY_HEIGHT-1:0]           p_row_select,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] p_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [PIXEL_BITS-1:0]                   out_data,
  output logic [ROW_W-1:0]                        out_row,
  output logic [COL_W-1:0]                        out_col,
  output logic                                    out_frame_start,
  output logic                                    out_frame_end,
  output logic                                    overflow,
  output logic                                    sel_error
);

  localparam int ROW_BITS = PIXEL_ARRAY_WIDTH * PIXEL_BITS;

  typedef struct packed {
    logic [ROW_W-1:0]    row;
    logic [ROW_BITS-1:0] data;
  } entry_t;

  // Input stage and sticky flags
  logic [PIXEL_ARRAY_HEIGHT-1:0] sel_q, sel_d;
  logic [ROW_BITS-1:0]           data_q, data_d;
  logic                          erase_q, erase_d;
  logic                          overflow_q, overflow_d;
  logic                          sel_error_q, sel_error_d;

  // Serialiser state and registered outputs
  ser_state_t                    state_q, state_d;
  logic                          valid_q, valid_d;
  logic [PIXEL_BITS-1:0]         pix_q, pix_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic [COL_W-1:0]              col_q, col_d;
  logic                          fs_q, fs_d;
  logic                          fe_q, fe_d;

  logic                          sel_ok_s;
  logic                          push_s;
  logic                          pop_s;
  logic                          load_s;
  logic [COL_W-1:0]              load_col_s;
  entry_t                        load_entry_s;
  entry_t                        push_entry_s;
  entry_t                        fifo_head_s;
  entry_t                        fifo_next_s;
  logic                          fifo_empty_s;
  logic                          fifo_full_s;

  row_fifo #(.entry_t(entry_t)) u_row_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head       (fifo_head_s),
    .next       (fifo_next_s),
    .empty      (fifo_empty_s),
    .full       (fifo_full_s)
  );

  // Capture a row one cycle after it is released; flag multi-row selects.
  always_comb begin
    sel_d             = p_row_select;
    data_d            = p_data;
    erase_d           = p_erase;
    sel_ok_s          = onehot_valid(32'(sel_q));
    push_s            = sel_ok_s && (p_row_select != sel_q);
    push_entry_s.row  = ROW_W'(onehot_encode(32'(sel_q)));
    push_entry_s.data = data_q;
    if (push_s && fifo_full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else if (p_erase && !erase_q) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if ((sel_q != '0) && !sel_ok_s) begin
      sel_error_d = 1'b1;
    end else if (p_erase && !erase_q) begin
      sel_error_d = 1'b0;
    end else begin
      sel_error_d = sel_error_q;
    end
  end

  // Serialiser: walk the head row column by column, chain rows without a bubble.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    pix_d        = pix_q;
    row_d        = row_q;
    col_d        = col_q;
    fs_d         = fs_q;
    fe_d         = fe_q;
    pop_s        = 1'b0;
    load_s       = 1'b0;
    load_entry_s = fifo_head_s;
    load_col_s   = '0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_d = ST_SEND;
          load_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (valid_q && out_ready) begin
          if (col_q != COL_W'(PIXEL_ARRAY_WIDTH - 1)) begin
            load_s     = 1'b1;
            load_col_s = col_q + COL_W'(1);
          end else begin
            pop_s = 1'b1;
            if (fifo_full_s) begin
              load_s       = 1'b1;
              load_entry_s = fifo_next_s;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_s) begin
      valid_d = 1'b1;
      pix_d   = load_entry_s.data[int'(load_col_s) * PIXEL_BITS +: PIXEL_BITS];
      row_d   = load_entry_s.row;
      col_d   = load_col_s;
      fs_d    = (load_entry_s.row == ROW_W'(0)) && (load_col_s == COL_W'(0));
      fe_d    = (load_entry_s.row == ROW_W'(PIXEL_ARRAY_HEIGHT - 1)) &&
                (load_col_s == COL_W'(PIXEL_ARRAY_WIDTH - 1));
    end else if (state_d == ST_IDLE) begin
      valid_d = 1'b0;
      pix_d   = '0;
      row_d   = '0;
      col_d   = '0;
      fs_d    = 1'b0;
      fe_d    = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // All state registers; reset discards everything including buffered rows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q       <= '0;
      data_q      <= '0;
      erase_q     <= 1'b0;
      overflow_q  <= 1'b0;
      sel_error_q <= 1'b0;
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      pix_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      data_q      <= data_d;
      erase_q     <= erase_d;
      overflow_q  <= overflow_d;
      sel_error_q <= sel_error_d;
      state_q     <= state_d;
      valid_q     <= valid_d;
      pix_q       <= pix_d;
      row_q       <= row_d;
      col_q       <= col_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_data        = pix_q;
  assign out_row         = row_q;
  assign out_col         = col_q;
  assign out_frame_start = fs_q;
  assign out_frame_end   = fe_q;
  assign overflow        = overflow_q;
  assign sel_error       = sel_error_q;

endmodule

// File: tb/tb_pixel_readout.sv
// Directed plus randomized bench for pixel_readout (W=4, H=4, 8-bit pixels).
// Expected pixels come from a queue filled whenever the bench releases a row.
module tb_pixel_readout;

  logic        clk;
  logic        reset;
  logic        p_erase;
  logic [3:0]  p_row_select;
  logic [31:0] p_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_row;
  logic [1:0]  out_col;
  logic        out_frame_start;
  logic        out_frame_end;
  logic        overflow;
  logic        sel_error;

  pixel_readout dut (
    .clk             (clk),
    .reset           (reset),
    .p_erase         (p_erase),
    .p_row_select    (p_row_select),
    .p_data          (p_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_row         (out_row),
    .out_col         (out_col),
    .out_frame_start (out_frame_start),
    .out_frame_end   (out_frame_end),
    .overflow        (overflow),
    .sel_error       (sel_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         r;
    int         c;
  } pix_t;

  pix_t        exp_q[$];
  int          passed;
  int          total;
  logic        mon_en;
  logic        prev_stall;
  logic [7:0]  prev_data;
  logic [1:0]  prev_row;
  logic [1:0]  prev_col;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // A released row contributes its four pixels, column 0 from the LSBs.
  task automatic push_row(input int r, input logic [31:0] d);
    for (int c = 0; c < 4; c++) begin
      pix_t p;
      p.d = d[c*8 +: 8];
      p.r = r;
      p.c = c;
      exp_q.push_back(p);
    end
  endtask

  // One clock: check the stream at the falling edge, return just after the rising edge.
  task automatic tick();
    pix_t e;
    @(negedge clk);
    if (mon_en) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
        chk("hold_row", 32'(out_row), 32'(prev_row));
        chk("hold_col", 32'(out_col), 32'(prev_col));
      end
      if (out_valid && out_ready) begin
        chk("pixel_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pix_data", 32'(out_data), 32'(e.d));
          chk("pix_row", 32'(out_row), 32'(e.r));
          chk("pix_col", 32'(out_col), 32'(e.c));
          chk("pix_fstart", 32'(out_frame_start), 32'(e.r == 0 && e.c == 0));
          chk("pix_fend", 32'(out_frame_end), 32'(e.r == 3 && e.c == 3));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_row   = out_row;
      prev_col   = out_col;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int          r;
    int          n;
    passed       = 0;
    total        = 0;
    mon_en       = 1'b0;
    prev_stall   = 1'b0;
    prev_data    = 8'd0;
    prev_row     = 2'd0;
    prev_col     = 2'd0;
    reset        = 1'b0;
    p_erase      = 1'b0;
    p_row_select = 4'd0;
    p_data       = 32'd0;
    out_ready    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", 32'({out_data, out_row, out_col, out_frame_start, out_frame_end}), 32'd0);
    chk("rst_flags", 32'({overflow, sel_error}), 32'd0);
    reset  = 1'b1;
    tick();
    mon_en = 1'b1;

    // Single row: latency and pixel order
    out_ready    = 1'b1;
    p_data       = 32'h44332211;
    p_row_select = 4'b0100;
    repeat (5) tick();
    p_row_select = 4'b0000;
    push_row(2, 32'h44332211);
    tick();
    chk("lat_early", 32'(out_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'h11);
    repeat (4) tick();
    chk("single_drained", 32'(exp_q.size()), 32'd0);
    chk("single_idle", 32'(out_valid), 32'd0);

    // Full frame: rows 0..3 back to back, 4 cycles each
    for (int i = 0; i < 4; i++) begin
      d            = $urandom;
      p_data       = d;
      p_row_select = 4'b0001 << i;
      push_row(i, d);
      repeat (4) tick();
    end
    p_row_select = 4'b0000;
    drain("frame_drained");

    // Backpressure: stall 10 cycles in the middle of a row
    d            = $urandom;
    p_data       = d;
    p_row_select = 4'b0010;
    repeat (3) tick();
    p_row_select = 4'b0000;
    push_row(1, d);
    repeat (3) tick();
    out_ready = 1'b0;
    repeat (10) tick();
    chk("bp_valid", 32'(out_valid), 32'd1);
    drain("bp_drained");

    // Overflow: three rows released with the sink stalled, third is dropped
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d            = $urandom;
      p_data       = d;
      p_row_select = 4'b0001 << i;
      if (i < 2) begin
        push_row(i, d);
      end
      repeat (2) tick();
    end
    p_row_select = 4'b0000;
    repeat (3) tick();
    chk("ovf_set", 32'(overflow), 32'd1);
    p_erase = 1'b1;
    tick();
    p_erase = 1'b0;
    tick();
    chk("ovf_clear", 32'(overflow), 32'd0);
    drain("ovf_drained");
    repeat (3) tick();
    chk("ovf_idle", 32'(out_valid), 32'd0);

    // Illegal select: two rows at once raises sel_error and emits nothing
    p_row_select = 4'b0110;
    repeat (3) tick();
    p_row_select = 4'b0000;
    repeat (4) tick();
    chk("sel_err_set", 32'(sel_error), 32'd1);
    chk("sel_err_quiet", 32'(out_valid), 32'd0);
    p_erase = 1'b1;
    tick();
    p_erase = 1'b0;
    tick();
    chk("sel_err_clear", 32'(sel_error), 32'd0);

    // Randomized rows with random sink readiness
    for (int i = 0; i < 24; i++) begin
      n = 0;
      while (exp_q.size() > 4 && n < 200) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end
      chk("rand_wait", 32'(exp_q.size() <= 4), 32'd1);
      r            = $urandom_range(0, 3);
      d            = $urandom;
      p_data       = d;
      p_row_select = 4'b0001 << r;
      repeat ($urandom_range(1, 4)) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      p_row_select = 4'b0000;
      push_row(r, d);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand_drained");
    chk("rand_flags", 32'({overflow, sel_error}), 32'd0);

    // Asynchronous reset in the middle of a row
    out_ready    = 1'b1;
    d            = $urandom;
    p_data       = d;
    p_row_select = 4'b0001;
    repeat (3) tick();
    p_row_select = 4'b0000;
    push_row(0, d);
    repeat (3) tick();
    chk("ar_sending", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_outs", 32'({out_data, out_row, out_col, out_frame_start, out_frame_end}), 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("ar_no_stale", 32'(out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
